// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the nibble-serial subtractor controller.
// Contents: FSM state encoding, nibble width.
package serial_subtract_ctrl_pkg;

   localparam int unsigned NIB_W = 4;

   // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtract_ctrl_if.sv
// Start/result handshake bundle for serial_subtract_ctrl.
// Signals:
//   start_valid / start_ready : operand handshake (requester -> controller)
//   A, B                      : minuend / subtrahend, W = 4*NIBBLES bits
//   DIFF, BORROW              : result, (A-B) mod 2^W and A<B flag
//   done_valid / done_ready   : result handshake (controller -> consumer)
// Modports: master = requester/consumer side, slave = controller side.
interface serial_subtract_ctrl_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] DIFF;
   logic         BORROW;
   logic         done_valid;
   logic         done_ready;

   modport master (
      output start_valid, A, B, done_ready,
      input  start_ready, DIFF, BORROW, done_valid
   );

   modport slave (
      input  start_valid, A, B, done_ready,
      output start_ready, DIFF, BORROW, done_valid
   );
endinterface

// File: rtl/serial_subtract_ctrl_nibble_sub_bin.sv
// 4-bit subtract slice with borrow-in.
// Ports:
//   a, b : 4-bit operands
//   bin  : borrow in
//   d    : (a - b - bin) mod 16
//   bout : borrow out, 1 iff a < b + bin
module nibble_sub_bin
   import serial_subtract_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             bin,
   output logic [NIB_W-1:0] d,
   output logic             bout
);

   logic [NIB_W:0] full;

   // One guard bit: a negative result leaves it set, which is exactly the borrow.
   always_comb begin
      full = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
      d    = full[NIB_W-1:0];
      bout = full[NIB_W];
   end

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Nibble-serial wide unsigned subtractor controller.
// Computes DIFF = A - B over NIBBLES 4-bit slices, one nibble per clock,
// LSB first, reusing a single borrow-in slice.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_subtract_ctrl_if.slave (start/result handshakes, A, B, DIFF, BORROW)
module serial_subtract_ctrl
   import serial_subtract_ctrl_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_subtract_ctrl_if.slave bus
);

   localparam int unsigned W  = NIB_W * NIBBLES;
   localparam int unsigned CW = $clog2(NIBBLES + 1);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   state_t          state;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic [CW-1:0]   cnt;
   logic            borrow_reg;
   logic            start_ready;
   logic            done_valid;
   logic [W-1:0]    diff;
   logic            borrow;

   logic [NIB_W-1:0] nib_d;
   logic             nib_bout;

   // Slice always works on the LSB nibble; operands shift down each RUN cycle.
   nibble_sub_bin u_slice (
      .a    (a_sh[NIB_W-1:0]),
      .b    (b_sh[NIB_W-1:0]),
      .bin  (borrow_reg),
      .d    (nib_d),
      .bout (nib_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_sh        <= '0;
         b_sh        <= '0;
         cnt         <= '0;
         borrow_reg  <= 1'b0;
         start_ready <= 1'b1;
         done_valid  <= 1'b0;
         diff        <= '0;
         borrow      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_valid && start_ready) begin
                  state       <= RUN;
                  a_sh        <= bus.A;
                  b_sh        <= bus.B;
                  cnt         <= '0;
                  borrow_reg  <= 1'b0;
                  diff        <= '0;
                  start_ready <= 1'b0;
               end
            end

            RUN: begin
               for (int unsigned i = 0; i < NIBBLES; i++) begin
                  if (cnt == CW'(i)) diff[i*NIB_W +: NIB_W] <= nib_d;
               end
               a_sh       <= a_sh >> NIB_W;
               b_sh       <= b_sh >> NIB_W;
               borrow_reg <= nib_bout;
               if (cnt == LAST) begin
                  // Counter stops at LAST so it never wraps.
                  state      <= DONE;
                  borrow     <= nib_bout;
                  done_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DONE: begin
               // A concurrent start_valid is not taken here; start_ready is
               // only raised once back in IDLE.
               if (bus.done_ready) begin
                  state       <= IDLE;
                  done_valid  <= 1'b0;
                  start_ready <= 1'b1;
               end
            end

            default: begin
               state       <= IDLE;
               done_valid  <= 1'b0;
               start_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.start_ready = start_ready;
   assign bus.done_valid  = done_valid;
   assign bus.DIFF        = diff;
   assign bus.BORROW      = borrow;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed self-checking bench for serial_subtract_ctrl with NIBBLES=4.
module tb_serial_subtract_ctrl;

   localparam int unsigned NIBBLES = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_asserts = 0;
   int n_fails   = 0;

   serial_subtract_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

   serial_subtract_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present operands at a negedge, accept at the following posedge (E0).
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.A = a;
      bus.B = b;
      check("ready_before_accept", {31'd0, bus.start_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      check("ready_after_accept", {31'd0, bus.start_ready}, 32'd0);
      check("diff_cleared_e0", {16'd0, bus.DIFF}, 32'd0);
   endtask

   // done_valid must be low for 4 negedges after E0 and high on the 5th.
   task automatic wait_result(input logic [15:0] ed, input logic eb);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("done_low_in_run", {31'd0, bus.done_valid}, 32'd0);
      end
      @(negedge clk);
      check("done_valid_latency", {31'd0, bus.done_valid}, 32'd1);
      check("diff", {16'd0, bus.DIFF}, {16'd0, ed});
      check("borrow", {31'd0, bus.BORROW}, {31'd0, eb});
   endtask

   task automatic finish_result();
      @(negedge clk);
      bus.done_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.done_ready = 1'b0;
      check("done_dropped", {31'd0, bus.done_valid}, 32'd0);
      check("ready_in_idle", {31'd0, bus.start_ready}, 32'd1);
   endtask

   initial begin
      bus.start_valid = 1'b0;
      bus.done_ready  = 1'b0;
      bus.A = '0;
      bus.B = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
      check("rst_done_valid", {31'd0, bus.done_valid}, 32'd0);
      check("rst_diff", {16'd0, bus.DIFF}, 32'd0);
      check("rst_borrow", {31'd0, bus.BORROW}, 32'd0);
      rst = 1'b0;

      // Basic op with exact latency
      start_op(16'h1234, 16'h0234);
      wait_result(16'h1000, 1'b0);
      finish_result();

      // Borrow across nibble boundary
      start_op(16'h0010, 16'h0001);
      wait_result(16'h000F, 1'b0);
      finish_result();

      // Full-width underflow, with partial-result checks
      start_op(16'h0000, 16'h0001);
      @(negedge clk);
      @(negedge clk);
      check("partial_e1", {16'd0, bus.DIFF}, 32'h0000_000F);
      @(negedge clk);
      check("partial_e2", {16'd0, bus.DIFF}, 32'h0000_00FF);
      @(negedge clk);
      check("partial_e3", {16'd0, bus.DIFF}, 32'h0000_0FFF);
      @(negedge clk);
      check("underflow_valid", {31'd0, bus.done_valid}, 32'd1);
      check("underflow_diff", {16'd0, bus.DIFF}, 32'h0000_FFFF);
      check("underflow_borrow", {31'd0, bus.BORROW}, 32'd1);
      finish_result();

      // Equal operands; next request held (with changed A/B) during RUN/DONE
      start_op(16'h5A5A, 16'h5A5A);
      bus.start_valid = 1'b1;
      bus.A = 16'h8000;
      bus.B = 16'h0001;
      wait_result(16'h0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, bus.done_valid}, 32'd1);
         check("hold_diff", {16'd0, bus.DIFF}, 32'd0);
         check("hold_borrow", {31'd0, bus.BORROW}, 32'd0);
         check("hold_ready_low", {31'd0, bus.start_ready}, 32'd0);
      end
      @(negedge clk);
      bus.done_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.done_ready = 1'b0;
      check("overlap_done_dropped", {31'd0, bus.done_valid}, 32'd0);
      check("overlap_not_accepted", {31'd0, bus.start_ready}, 32'd1);
      check("idle_keeps_diff", {16'd0, bus.DIFF}, 32'd0);
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      check("overlap_accepted_next", {31'd0, bus.start_ready}, 32'd0);
      wait_result(16'h7FFF, 1'b0);
      finish_result();

      // Reset at RUN edge E2
      start_op(16'h1111, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_start_ready", {31'd0, bus.start_ready}, 32'd1);
      check("abort_done_valid", {31'd0, bus.done_valid}, 32'd0);
      check("abort_diff", {16'd0, bus.DIFF}, 32'd0);
      check("abort_borrow", {31'd0, bus.BORROW}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_done", {31'd0, bus.done_valid}, 32'd0);
         check("abort_idle_ready", {31'd0, bus.start_ready}, 32'd1);
      end

      start_op(16'hFFFF, 16'h0001);
      wait_result(16'hFFFE, 1'b0);
      finish_result();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
- Nibble-serial wide unsigned subtractor controller.
- Computes DIFF = A - B over NIBBLES x 4 bits by reusing one 4-bit borrow-in subtract slice, one nibble per clock, LSB nibble first.
- Sits between a requester (valid/ready start handshake) and a consumer (valid/ready result handshake).
- Trades latency for area versus a full-width ripple subtractor.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start_valid  in  1  requester presents operands
- start_ready  out  1  controller can accept operands
- A  in  W  minuend, unsigned
- B  in  W  subtrahend, unsigned
- DIFF  out  W  result, (A - B) mod 2^W
- BORROW  out  1  final borrow; 1 iff A < B unsigned
- done_valid  out  1  DIFF/BORROW valid
- done_ready  in  1  consumer accepts result

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, start_ready=1, done_valid=0, DIFF=0, BORROW=0; internal operand regs, nibble counter and borrow reg all 0.
- States:
  - IDLE: start_ready=1, done_valid=0.
  - RUN: start_ready=0, done_valid=0.
  - DONE: start_ready=0, done_valid=1.
- IDLE -> RUN on start_valid & start_ready at an edge (accept edge E0).
  - At E0, A and B are latched into shift regs, the counter is cleared and borrow_reg is cleared.
  - A and B are ignored at all other times.
- RUN edges E1..EN process nibble k = 0..N-1:
  - {bout, d} = a_nib - b_nib - borrow_reg.
  - d is written to DIFF[4k+3:4k] and borrow_reg <= bout.
  - DIFF nibbles not yet processed hold 0, since DIFF is cleared at E0.
- At EN, RUN -> DONE; BORROW <= final bout.
  - done_valid is first high in the cycle after EN, i.e. latency exactly NIBBLES cycles after the accept edge.
- DONE: DIFF, BORROW and done_valid hold stable until done_ready=1 at an edge, then -> IDLE with done_valid=0.
  - DIFF and BORROW keep their last values in IDLE until the next accept.
- No overlap: start_valid in RUN or DONE is not accepted (start_ready=0); the requester must hold start_valid.
  - Minimum initiation interval is NIBBLES + 2 cycles (one IDLE bubble after DONE).
- Simultaneous done_ready and start_valid in DONE: only the result handshake completes; the new start is accepted no earlier than the following edge in IDLE.
- rst asserted in any state, including mid-RUN: the operation is aborted and the controller returns to reset values at that edge; no done_valid pulse occurs for the aborted operation.
- Width rules:
  - Subtraction is modulo 2^W.
  - The borrow chain crosses nibbles only via borrow_reg, never combinationally.
  - NIBBLES=1 degenerates to a single RUN cycle.
- Counter is ceil(log2(NIBBLES+1)) bits; it must not wrap in RUN.

Decomposition:
- Shared header (sub_defs.vh):
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIB_W=4.
  - Encoding 2'd3 is illegal and recovers to IDLE.
- Sub-module nibble_sub_bin: combinational a[3:0], b[3:0], bin -> d[3:0], bout.
  - Instanced once and fed from the LSB nibble of the operand shift regs.
  - Kept separate because the existing four_bit_subtractor has no borrow input.

Test Plan:
- NIBBLES=4: A=16'h1234, B=16'h0234 accepted -> exactly 4 cycles later done_valid=1, DIFF=16'h1000, BORROW=0.
- A=16'h0010, B=16'h0001 -> DIFF=16'h000F, BORROW=0 (borrow crosses the nibble boundary).
- A=16'h0000, B=16'h0001 -> DIFF=16'hFFFF, BORROW=1.
- A=B=16'h5A5A -> DIFF=16'h0000, BORROW=0.
- Hold done_ready=0 for 5 cycles after done_valid -> DIFF and BORROW stable, start_ready=0.
  - A start_valid presented during RUN/DONE is not accepted until the edge after returning to IDLE.
- Assert rst for 1 cycle at RUN edge E2 -> next cycle all outputs at reset values, start_ready=1, no done_valid.
  - A fresh A=16'hFFFF, B=16'h0001 then yields DIFF=16'hFFFE, BORROW=0.
